// File: rtl/genblk_ser_pkg.sv
// genblk_ser_pkg: shared types and lane/frame sizing for the lane serializer (optional GENBLK_SER_PARITY_EN)
package genblk_ser_pkg;
`ifdef GENBLK_SER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  typedef enum logic {IDLE, SEND} ser_state_t;
  function automatic int lane_w(input int i);
    return PARITY_EN ? i + 2 : i + 1;
  endfunction
  function automatic int frame_len(input int lanes);
    return PARITY_EN ? lanes * (lanes + 3) / 2 : lanes * (lanes + 1) / 2;
  endfunction
endpackage

// File: rtl/genblk_ser_lane.sv
// genblk_ser_lane: one lane register with its frame snapshot, bit select and parity
module genblk_ser_lane #(
  parameter int W  = 1,
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          snap,
  input  logic [W-1:0]  d,
  input  logic [BW-1:0] sel,
  output logic          b,
  output logic          p
);
  localparam int EW = 2 ** BW;
  logic [W-1:0]  q, s;
  logic [EW-1:0] ext;
  // live register takes host writes; shadow samples the pre-write value on snap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      s <= '0;
    end else begin
      if (we) q <= d;
      if (snap) s <= q;
    end
  assign ext = EW'(s);
  assign b   = ext[sel];
  assign p   = ^s;
endmodule

// File: rtl/genblk_lane_serializer.sv
// genblk_lane_serializer: generate-built lane bank streamed out bit-serially (parity via GENBLK_SER_PARITY_EN)
module genblk_lane_serializer
  import genblk_ser_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LSEL  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [LSEL-1:0] wr_lane,
  input  logic [LANES-1:0] wr_data,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [LSEL-1:0] out_lane,
  output logic            out_last
);
  localparam int MAXW = lane_w(LANES - 1);
  localparam int BW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int NL   = 2 ** LSEL;
  ser_state_t       st, nxt;
  logic [LSEL-1:0]  lc;
  logic [BW-1:0]    bc, bend;
  logic [LANES-1:0] bits, pars;
  logic [NL-1:0]    bits_x, pars_x;
  logic             acc, hs, last;
  for (genvar i = 0; i < LANES; i++) begin : lane
    localparam int LW = i + 1;
    genblk_ser_lane #(.W(LW), .BW(BW)) u (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && wr_lane == LSEL'(i)),
      .snap(acc),
      .d   (wr_data[LW-1:0]),
      .sel (bc),
      .b   (bits[i]),
      .p   (pars[i])
    );
  end
  assign bits_x = NL'(bits);
  assign pars_x = NL'(pars);
  assign bend   = BW'(lc) + BW'(PARITY_EN);
  assign last   = lc == LSEL'(LANES - 1) && bc == bend;
  // start acceptance, handshake and next state
  always_comb begin
    acc = st == IDLE && start;
    hs  = st == SEND && out_ready;
    nxt = acc ? SEND : (hs && last) ? IDLE : st;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  // lane/bit position walks the snapshot one handshake at a time
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lc <= '0;
      bc <= '0;
    end else if (acc || (hs && last)) begin
      lc <= '0;
      bc <= '0;
    end else if (hs) begin
      bc <= (bc == bend) ? '0 : bc + BW'(1);
      lc <= (bc == bend) ? lc + LSEL'(1) : lc;
    end
  assign busy      = st == SEND;
  assign out_valid = st == SEND;
  assign out_bit   = (PARITY_EN && bc == bend) ? pars_x[lc] : bits_x[lc];
  assign out_lane  = lc;
  assign out_last  = out_valid && last;
endmodule

// File: tb/tb_genblk_lane_serializer.sv
// tb_genblk_lane_serializer: directed bench with a frame-level reference model
module tb_genblk_lane_serializer;
  localparam int LANES = 4;
  localparam int LSEL  = 2;
`ifdef GENBLK_SER_PARITY_EN
  localparam int FL = 14;
  localparam int L3 = 9;
`else
  localparam int FL = 10;
  localparam int L3 = 6;
`endif
  typedef struct {bit b; int l; bit last;} ent_t;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, out_ready = 1;
  logic [LSEL-1:0] wr_lane = '0;
  logic [LANES-1:0] wr_data = '0;
  logic busy, out_valid, out_bit, out_last;
  logic [LSEL-1:0] out_lane;
  int total = 0, bad = 0, rxn = 0, held = 0, frames = 0, lastpos = -1;
  int mdl[LANES];
  bit active = 0;
  ent_t q[$];
  logic [31:0] rxv = '0;
  genblk_lane_serializer #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_data(wr_data),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_lane(out_lane), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic build();
    ent_t e;
    q.delete();
    for (int i = 0; i < LANES; i++) begin
      bit par = 0;
      for (int b = 0; b <= i; b++) begin
        e.b = bit'((mdl[i] >> b) & 1);
        e.l = i;
        e.last = 0;
        par ^= e.b;
        q.push_back(e);
      end
`ifdef GENBLK_SER_PARITY_EN
      e.b = par;
      e.l = i;
      e.last = 0;
      q.push_back(e);
`endif
    end
    q[q.size()-1].last = 1;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bit", 32'(out_bit), 0);
      chk("rst_lane", 32'(out_lane), 0);
      chk("rst_last", 32'(out_last), 0);
    end else begin
      chk("busy", 32'(busy), 32'(active));
      chk("valid", 32'(out_valid), 32'(active));
      if (active && q.size() > 0) begin
        chk("bit", 32'(out_bit), 32'(q[0].b));
        chk("lane", 32'(out_lane), 32'(q[0].l));
        chk("last", 32'(out_last), 32'(q[0].last));
        if (rxn == 3) held++;
        if (out_ready) begin
          rxv[rxn] = out_bit;
          if (q[0].last) begin
            active = 0;
            frames++;
            lastpos = rxn;
          end
          rxn++;
          q.pop_front();
        end
      end else chk("idle_last", 32'(out_last), 0);
    end
  end
  task automatic do_write(input int l, input int d);
    wr_en = 1; wr_lane = LSEL'(l); wr_data = LANES'(d);
    @(posedge clk); #1;
    wr_en = 0;
    mdl[l] = d & ((1 << (l + 1)) - 1);
  endtask
  task automatic do_start(input bit with_wr, input int l, input int d);
    start = 1;
    if (with_wr) begin wr_en = 1; wr_lane = LSEL'(l); wr_data = LANES'(d); end
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    if (!active) begin build(); active = 1; end
    if (with_wr) mdl[l] = d & ((1 << (l + 1)) - 1);
  endtask
  task automatic wait_done();
    int n = 0;
    while (active && n < 200) begin @(posedge clk); n++; end
    #1;
    if (active) begin
      chk("frame_timeout", 1, 0);
      active = 0;
      q.delete();
    end
  endtask
  task automatic wait_rx(input int k);
    int n = 0;
    while (rxn < k && n < 100) begin @(posedge clk); n++; end
    #1;
    if (rxn < k) chk("rx_timeout", 32'(rxn), 32'(k));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int f0;
    foreach (mdl[i]) mdl[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    do_write(0, 1); do_write(1, 2); do_write(2, 5); do_write(3, 6);
    do_write(3, 6 | 16);
    rxn = 0;
    do_start(0, 0, 0);
    wait_done();
`ifdef GENBLK_SER_PARITY_EN
    chk("basic_seq", 32'(rxv[13:0]), 32'h0CBB);
`else
    chk("basic_seq", 32'(rxv[9:0]), 32'h1AD);
`endif
    chk("basic_lastpos", 32'(lastpos), 32'(FL - 1));
    @(posedge clk); #1;
    chk("busy_after", 32'(busy), 0);
    rxn = 0; held = 0;
    do_start(0, 0, 0);
    wait_rx(3);
    out_ready = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    wait_done();
    chk("bp_held", 32'(held), 4);
`ifndef GENBLK_SER_PARITY_EN
    chk("bp_seq", 32'(rxv[9:0]), 32'h1AD);
`endif
    rxn = 0;
    do_start(0, 0, 0);
    wait_rx(1);
    do_write(3, 15);
    wait_done();
    chk("wdf_old", 32'(rxv[L3+3 -: 4]), 32'h6);
    rxn = 0;
    do_start(0, 0, 0);
    wait_done();
    chk("wdf_new", 32'(rxv[L3+3 -: 4]), 32'hF);
    rxn = 0; f0 = frames;
    do_start(1, 0, 0);
    repeat (2) @(posedge clk);
    #1 do_start(0, 0, 0);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("sw_bit1", 32'(rxv[0]), 1);
    chk("one_frame", 32'(frames - f0), 1);
    rxn = 0;
    do_start(0, 0, 0);
    wait_rx(4);
    rst = 1;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_lane", 32'(out_lane), 0);
    active = 0; q.delete();
    foreach (mdl[i]) mdl[i] = 0;
    @(posedge clk); #1 rst = 0;
    rxn = 0; rxv = '1;
    do_start(0, 0, 0);
    wait_done();
    chk("mr_zero", 32'(rxv[FL-1:0]), 0);
    chk("mr_len", 32'(rxn), 32'(FL));
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
